// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source codes.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_IMM  = 2'd2,
    WB_SRC_LINK = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bus between the pipeline and the writeback stage: MEM/WB payload, forwarding
// outputs, register read ports and the retire counter.
interface wb_stage_if import wb_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int CNT_W  = 16
);
  localparam int REG_AW = $clog2(NREGS);

  logic              in_valid;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic              in_wr;
  wb_src_e           in_src;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_mem;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_link;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [REG_AW-1:0] ra_addr;
  logic [REG_AW-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    output in_valid, stall, flush, in_wr, in_src, in_rd,
           in_alu, in_mem, in_imm, in_link, ra_addr, rb_addr,
    input  in_ready, fwd_valid, fwd_rd, fwd_data, ra_data, rb_data, retired_cnt
  );

  modport slave (
    input  in_valid, stall, flush, in_wr, in_src, in_rd,
           in_alu, in_mem, in_imm, in_link, ra_addr, rb_addr,
    output in_ready, fwd_valid, fwd_rd, fwd_data, ra_data, rb_data, retired_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two asynchronous read ports,
// cleared by reset; optionally register 0 is hard-wired to zero.
module wb_regfile #(
  parameter int  DATA_W  = 8,
  parameter int  NREGS   = 4,
  parameter bit  ZERO_R0 = 1'b0,
  localparam int REG_AW  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] ra_addr_i,
  input  logic [REG_AW-1:0] rb_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic              wr_en;

  // Writes to r0 are dropped, so it keeps its reset value of zero forever.
  assign wr_en = we_i && !(ZERO_R0 && (waddr_i == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = mem_q[ra_addr_i];
  assign rb_data_o = mem_q[rb_addr_i];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: latches the selected result, commits it to the register
// file one edge later, bypasses it to the read ports and counts retirements.
module wb_stage import wb_pkg::*; #(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 4,
  parameter bit ZERO_R0 = 1'b0,
  parameter int CNT_W   = 16
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);
  localparam int REG_AW = $clog2(NREGS);

  logic              s_valid_q, s_valid_d;
  logic              s_wr_q, s_wr_d;
  logic [REG_AW-1:0] s_rd_q, s_rd_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rf_ra_data, rf_rb_data;
  logic              rd_is_zero, fwd_valid, commit;

  always_comb begin
    sel_data = bus.in_alu;
    case (bus.in_src)
      WB_SRC_ALU:  sel_data = bus.in_alu;
      WB_SRC_MEM:  sel_data = bus.in_mem;
      WB_SRC_IMM:  sel_data = bus.in_imm;
      WB_SRC_LINK: sel_data = bus.in_link;
    endcase
  end

  assign rd_is_zero = ZERO_R0 && (s_rd_q == '0);
  assign fwd_valid  = s_valid_q & s_wr_q & ~rd_is_zero;
  assign commit     = s_valid_q & ~bus.stall;

  always_comb begin
    s_valid_d = s_valid_q;
    s_wr_d    = s_wr_q;
    s_rd_d    = s_rd_q;
    s_data_d  = s_data_q;
    cnt_d     = cnt_q;
    // Flush only matters when the stage actually captures; a stalled stage holds.
    if (!bus.stall) begin
      s_valid_d = bus.in_valid & ~bus.flush;
      s_wr_d    = bus.in_wr;
      s_rd_d    = bus.in_rd;
      s_data_d  = sel_data;
    end
    if (commit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_wr_q    <= 1'b0;
      s_rd_q    <= '0;
      s_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_wr_q    <= s_wr_d;
      s_rd_q    <= s_rd_d;
      s_data_q  <= s_data_d;
      cnt_q     <= cnt_d;
    end
  end

  wb_regfile #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .ZERO_R0 (ZERO_R0)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (commit & s_wr_q),
    .waddr_i   (s_rd_q),
    .wdata_i   (s_data_q),
    .ra_addr_i (bus.ra_addr),
    .rb_addr_i (bus.rb_addr),
    .ra_data_o (rf_ra_data),
    .rb_data_o (rf_rb_data)
  );

  // The in-stage entry is younger than anything in the file, so it wins.
  assign bus.ra_data = (fwd_valid && (bus.ra_addr == s_rd_q)) ? s_data_q : rf_ra_data;
  assign bus.rb_data = (fwd_valid && (bus.rb_addr == s_rd_q)) ? s_data_q : rf_rb_data;

  assign bus.in_ready    = ~bus.stall;
  assign bus.fwd_valid   = fwd_valid;
  assign bus.fwd_rd      = s_rd_q;
  assign bus.fwd_data    = s_data_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a default instance and a ZERO_R0=1/CNT_W=2 instance share
// stimulus; directed table plus random traffic checked against a queue model.
module tb_wb_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(8), .NREGS(4), .CNT_W(16)) bus_a ();
  wb_stage_if #(.DATA_W(8), .NREGS(4), .CNT_W(2))  bus_b ();

  wb_stage #(.DATA_W(8), .NREGS(4), .ZERO_R0(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  wb_stage #(.DATA_W(8), .NREGS(4), .ZERO_R0(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending in-flight instructions and architectural state.
  typedef struct { logic wr; logic [1:0] rd; logic [7:0] data; } ent_t;
  ent_t       pend[$];
  logic [7:0] regs [2][4];
  int         cnt [2];
  int         cnt_max [2] = '{65535, 3};

  logic       cur_v, cur_st, cur_fl, cur_wr;
  logic [1:0] cur_rd, cur_ra, cur_rb;
  logic [7:0] cur_val;

  typedef struct {
    logic v, st, fl, wr; logic [1:0] src, rd; logic [7:0] val; logic [1:0] ra, rb;
    logic e_fv; logic [1:0] e_frd; logic [7:0] e_fd, e_ra, e_rb; int e_cnt; logic e_rdy;
  } vec_t;
  vec_t tbl [21];

  function automatic vec_t mk(logic v, logic st, logic fl, logic wr, logic [1:0] src,
      logic [1:0] rd, logic [7:0] val, logic [1:0] ra, logic [1:0] rb, logic e_fv,
      logic [1:0] e_frd, logic [7:0] e_fd, logic [7:0] e_ra, logic [7:0] e_rb,
      int e_cnt, logic e_rdy);
    vec_t r;
    r.v = v; r.st = st; r.fl = fl; r.wr = wr; r.src = src; r.rd = rd; r.val = val;
    r.ra = ra; r.rb = rb; r.e_fv = e_fv; r.e_frd = e_frd; r.e_fd = e_fd;
    r.e_ra = e_ra; r.e_rb = e_rb; r.e_cnt = e_cnt; r.e_rdy = e_rdy;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    pend.delete();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0;
      for (int r = 0; r < 4; r++) regs[m][r] = 8'h00;
    end
  endfunction

  function automatic void model_edge();
    ent_t e;
    if (cur_st) return;
    if (pend.size() > 0) begin
      e = pend.pop_front();
      for (int m = 0; m < 2; m++) begin
        if (cnt[m] < cnt_max[m]) cnt[m]++;
        if (e.wr && !(m == 1 && e.rd == 2'd0)) regs[m][e.rd] = e.data;
      end
    end
    if (cur_v && !cur_fl) begin
      e.wr = cur_wr; e.rd = cur_rd; e.data = cur_val;
      pend.push_back(e);
    end
  endfunction

  function automatic logic exp_fv(int m);
    return pend.size() > 0 && pend[0].wr && !(m == 1 && pend[0].rd == 2'd0);
  endfunction

  function automatic logic [7:0] exp_read(int m, logic [1:0] a);
    if (m == 1 && a == 2'd0) return 8'h00;
    if (exp_fv(m) && pend[0].rd == a) return pend[0].data;
    return regs[m][a];
  endfunction

  task automatic drive(input logic v, input logic st, input logic fl, input logic wr,
                       input logic [1:0] src, input logic [1:0] rd, input logic [7:0] val,
                       input logic [1:0] ra, input logic [1:0] rb);
    logic [7:0] srcv [4];
    for (int k = 0; k < 4; k++) srcv[k] = 8'($urandom);
    srcv[src] = val;
    cur_v = v; cur_st = st; cur_fl = fl; cur_wr = wr; cur_rd = rd;
    cur_val = val; cur_ra = ra; cur_rb = rb;
    bus_a.in_valid = v; bus_a.stall = st; bus_a.flush = fl; bus_a.in_wr = wr;
    bus_a.in_src = wb_src_e'(src); bus_a.in_rd = rd; bus_a.ra_addr = ra; bus_a.rb_addr = rb;
    bus_a.in_alu = srcv[0]; bus_a.in_mem = srcv[1]; bus_a.in_imm = srcv[2]; bus_a.in_link = srcv[3];
    bus_b.in_valid = v; bus_b.stall = st; bus_b.flush = fl; bus_b.in_wr = wr;
    bus_b.in_src = wb_src_e'(src); bus_b.in_rd = rd; bus_b.ra_addr = ra; bus_b.rb_addr = rb;
    bus_b.in_alu = srcv[0]; bus_b.in_mem = srcv[1]; bus_b.in_imm = srcv[2]; bus_b.in_link = srcv[3];
  endtask

  task automatic cmp_model(input string tag, input int m);
    logic fv, rdy; logic [1:0] frd; logic [7:0] fd, rad, rbd; logic [31:0] c;
    if (m == 0) begin
      fv = bus_a.fwd_valid; frd = bus_a.fwd_rd; fd = bus_a.fwd_data; rdy = bus_a.in_ready;
      rad = bus_a.ra_data; rbd = bus_a.rb_data; c = 32'(bus_a.retired_cnt);
    end else begin
      fv = bus_b.fwd_valid; frd = bus_b.fwd_rd; fd = bus_b.fwd_data; rdy = bus_b.in_ready;
      rad = bus_b.ra_data; rbd = bus_b.rb_data; c = 32'(bus_b.retired_cnt);
    end
    check($sformatf("%s_fwd_valid_%0d", tag, m), 32'(fv), 32'(exp_fv(m)));
    if (exp_fv(m)) begin
      check($sformatf("%s_fwd_rd_%0d", tag, m), 32'(frd), 32'(pend[0].rd));
      check($sformatf("%s_fwd_data_%0d", tag, m), 32'(fd), 32'(pend[0].data));
    end
    check($sformatf("%s_ra_data_%0d", tag, m), 32'(rad), 32'(exp_read(m, cur_ra)));
    check($sformatf("%s_rb_data_%0d", tag, m), 32'(rbd), 32'(exp_read(m, cur_rb)));
    check($sformatf("%s_retired_cnt_%0d", tag, m), c, 32'(cnt[m]));
    check($sformatf("%s_in_ready_%0d", tag, m), 32'(rdy), 32'(!cur_st));
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      bus_a.ra_addr = 2'(a); bus_a.rb_addr = 2'(3 - a);
      bus_b.ra_addr = 2'(a); bus_b.rb_addr = 2'(3 - a);
      #1;
      check({tag, "_ra_a"}, 32'(bus_a.ra_data), 32'h0);
      check({tag, "_rb_a"}, 32'(bus_a.rb_data), 32'h0);
      check({tag, "_ra_b"}, 32'(bus_b.ra_data), 32'h0);
      check({tag, "_rb_b"}, 32'(bus_b.rb_data), 32'h0);
    end
    check({tag, "_fwd_valid_a"}, 32'(bus_a.fwd_valid), 32'h0);
    check({tag, "_fwd_rd_a"}, 32'(bus_a.fwd_rd), 32'h0);
    check({tag, "_fwd_data_a"}, 32'(bus_a.fwd_data), 32'h0);
    check({tag, "_fwd_valid_b"}, 32'(bus_b.fwd_valid), 32'h0);
    check({tag, "_cnt_a"}, 32'(bus_a.retired_cnt), 32'h0);
    check({tag, "_cnt_b"}, 32'(bus_b.retired_cnt), 32'h0);
  endtask

  initial begin
    // v st fl wr src rd val ra rb | fv frd fd ra rb cnt rdy  (expectations for ZERO_R0=0, CNT_W=16)
    tbl[0]  = mk(0,0,0,0,0,0,8'h00,2,1, 0,0,8'h00,8'h00,8'h00,0,1);
    tbl[1]  = mk(1,0,0,1,1,2,8'hA5,2,0, 1,2,8'hA5,8'hA5,8'h00,0,1);
    tbl[2]  = mk(0,0,0,0,0,0,8'h00,2,2, 0,0,8'h00,8'hA5,8'hA5,1,1);
    tbl[3]  = mk(1,0,0,1,0,1,8'h11,2,1, 1,1,8'h11,8'hA5,8'h11,1,1);
    tbl[4]  = mk(1,0,0,1,2,1,8'h22,2,1, 1,1,8'h22,8'hA5,8'h22,2,1);
    tbl[5]  = mk(0,0,0,0,0,0,8'h00,2,1, 0,0,8'h00,8'hA5,8'h22,3,1);
    tbl[6]  = mk(0,0,0,0,0,0,8'h00,2,1, 0,0,8'h00,8'hA5,8'h22,3,1);
    tbl[7]  = mk(1,0,0,1,3,3,8'h3C,3,1, 1,3,8'h3C,8'h3C,8'h22,3,1);
    tbl[8]  = mk(1,1,0,1,0,0,8'h77,3,1, 1,3,8'h3C,8'h3C,8'h22,3,0);
    tbl[9]  = mk(1,1,0,1,0,0,8'h77,3,1, 1,3,8'h3C,8'h3C,8'h22,3,0);
    tbl[10] = mk(1,1,0,1,0,0,8'h77,3,1, 1,3,8'h3C,8'h3C,8'h22,3,0);
    tbl[11] = mk(0,0,0,0,0,0,8'h00,3,1, 0,0,8'h00,8'h3C,8'h22,4,1);
    tbl[12] = mk(1,0,1,1,0,1,8'h99,3,1, 0,0,8'h00,8'h3C,8'h22,4,1);
    tbl[13] = mk(0,0,0,0,0,0,8'h00,3,1, 0,0,8'h00,8'h3C,8'h22,4,1);
    tbl[14] = mk(1,0,0,1,2,0,8'hFF,0,1, 1,0,8'hFF,8'hFF,8'h22,4,1);
    tbl[15] = mk(0,0,0,0,0,0,8'h00,0,1, 0,0,8'h00,8'hFF,8'h22,5,1);
    tbl[16] = mk(1,0,0,0,0,2,8'h55,2,1, 0,0,8'h00,8'hA5,8'h22,5,1);
    tbl[17] = mk(0,0,0,0,0,0,8'h00,2,1, 0,0,8'h00,8'hA5,8'h22,6,1);
    tbl[18] = mk(1,0,0,1,0,2,8'h66,2,3, 1,2,8'h66,8'h66,8'h3C,6,1);
    tbl[19] = mk(1,1,1,1,0,1,8'h99,2,3, 1,2,8'h66,8'h66,8'h3C,6,0);
    tbl[20] = mk(0,0,0,0,0,0,8'h00,2,3, 0,0,8'h00,8'h66,8'h3C,7,1);

    model_reset();
    drive(0,0,0,0,0,0,8'h00,0,0);
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].wr, tbl[i].src, tbl[i].rd,
            tbl[i].val, tbl[i].ra, tbl[i].rb);
      @(posedge clk); #1;
      model_edge();
      $display("vec %0d: v=%0b st=%0b fl=%0b rd=%0d val=%02h -> fv=%0b ra=%02h rb=%02h cnt=%0d",
               i, tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].rd, tbl[i].val,
               bus_a.fwd_valid, bus_a.ra_data, bus_a.rb_data, bus_a.retired_cnt);
      check($sformatf("vec%0d_fwd_valid", i), 32'(bus_a.fwd_valid), 32'(tbl[i].e_fv));
      if (tbl[i].e_fv) begin
        check($sformatf("vec%0d_fwd_rd", i), 32'(bus_a.fwd_rd), 32'(tbl[i].e_frd));
        check($sformatf("vec%0d_fwd_data", i), 32'(bus_a.fwd_data), 32'(tbl[i].e_fd));
      end
      check($sformatf("vec%0d_ra_data", i), 32'(bus_a.ra_data), 32'(tbl[i].e_ra));
      check($sformatf("vec%0d_rb_data", i), 32'(bus_a.rb_data), 32'(tbl[i].e_rb));
      check($sformatf("vec%0d_retired_cnt", i), 32'(bus_a.retired_cnt), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_in_ready", i), 32'(bus_a.in_ready), 32'(tbl[i].e_rdy));
      cmp_model($sformatf("vec%0d", i), 1);
      // Hand-derived corner cases for the ZERO_R0=1 / CNT_W=2 instance.
      if (i == 14) check("zr0_write_fwd_valid_b", 32'(bus_b.fwd_valid), 32'h0);
      if (i == 15) check("zr0_read_b", 32'(bus_b.ra_data), 32'h0);
    end
    check("cnt_saturated_b", 32'(bus_b.retired_cnt), 32'h3);

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 6) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
            8'($urandom), 2'($urandom), 2'($urandom));
      @(posedge clk); #1;
      model_edge();
      $display("txn %0d: v=%0b st=%0b fl=%0b wr=%0b rd=%0d val=%02h ra=%0d:%02h rb=%0d:%02h cnt=%0d",
               i, cur_v, cur_st, cur_fl, cur_wr, cur_rd, cur_val, cur_ra, bus_a.ra_data,
               cur_rb, bus_a.rb_data, bus_a.retired_cnt);
      cmp_model($sformatf("rnd%0d", i), 0);
      cmp_model($sformatf("rnd%0d", i), 1);
    end

    // Asynchronous reset in the middle of a cycle, with a live entry loaded.
    drive(1, 0, 0, 1, 2, 1, 8'hC3, 1, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 check_all_zero("rst_held");
    drive(0,0,0,0,0,0,8'h00,0,0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0, 1'($urandom),
            2'($urandom), 2'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));
      @(posedge clk); #1;
      model_edge();
      $display("post %0d: v=%0b st=%0b rd=%0d val=%02h cnt=%0d",
               i, cur_v, cur_st, cur_rd, cur_val, bus_a.retired_cnt);
      cmp_model($sformatf("post%0d", i), 0);
      cmp_model($sformatf("post%0d", i), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised writeback stage for the 8-bit processor pipeline, successor to the single-mux writeback. Latches the MEM/WB payload, selects one of four result sources, commits to an internal register file with one write port and two bypassed read ports, and exports forwarding data and a retired-instruction count. Sits at the end of the pipeline; decode reads operands from its read ports, and execute takes its forwarding outputs.

## Interface
- DATA_W, 8, datapath width
- NREGS, 4, register count (power of two, ≥2); REG_AW = $clog2(NREGS)
- ZERO_R0, 0, 1 = register 0 hard-wired to zero (writes dropped, reads return 0)
- CNT_W, 16, retire counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  payload valid
- in_ready  out  1  stage accepts payload; equals !stall
- stall  in  1  hold stage contents, no commit
- flush  in  1  discard incoming payload
- in_wr  in  1  instruction writes a register
- in_src  in  2  source: 0 ALU, 1 MEM, 2 IMM, 3 LINK
- in_rd  in  REG_AW  destination register
- in_alu, in_mem, in_imm, in_link  in  DATA_W  candidate results
- fwd_valid  out  1  stage holds a valid writing instruction (after ZERO_R0 masking)
- fwd_rd  out  REG_AW  stage destination
- fwd_data  out  DATA_W  stage selected result
- ra_addr, rb_addr  in  REG_AW  read addresses
- ra_data, rb_data  out  DATA_W  read data, combinational
- retired_cnt  out  CNT_W  committed instructions, saturating

## Operation
- Stage register: s_valid, s_wr, s_rd, s_data. Source mux is applied at capture; s_data stores the selected value.
- Capture at edge when !stall: s_valid <= in_valid & !flush; other fields load unconditionally.
- stall=1: all stage fields hold; no commit; in_ready=0. flush is ignored while stall=1 (upstream holds its payload).
- Commit: at edge where s_valid & !stall, if s_wr and !(ZERO_R0 & s_rd==0), regfile[s_rd] <= s_data; retired_cnt increments whenever s_valid & !stall, irrespective of s_wr.
- retired_cnt saturates at 2^CNT_W-1.
- Read ports: if fwd_valid and addr==s_rd, return s_data (bypass); else regfile[addr]. With ZERO_R0=1, addr 0 always returns 0.
- fwd_valid = s_valid & s_wr & !(ZERO_R0 & s_rd==0).
- Reset: s_valid=0, s_wr=0, s_rd=0, s_data=0, regfile all 0, retired_cnt=0; hence fwd_* = 0 and ra/rb_data = 0.

## Timing
- Payload accepted at edge E appears on fwd_* and read bypass during cycle E..E+1; reaches regfile at edge E+1 (if not stalled). Input-to-architectural-state latency: 2 edges.
- Back-to-back same rd: younger entry in stage shadows the older committed value; bypass always returns the youngest.
- Commit and capture at the same edge are both performed (single-entry pipeline, no bubble).
- Reset asserted mid-operation: stage and regfile cleared immediately, pending entry lost, counter cleared.

## Structure
- Package wb_pkg: source codes WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_IMM=2, WB_SRC_LINK=3 as a 2-bit typedef.
- Sub-module wb_regfile (NREGS×DATA_W, one write port, two async read ports, async reset clear, ZERO_R0 handling); bypass and source mux stay in wb_stage.

## Test plan
- Reset, then read all addresses -> ra/rb_data=0, retired_cnt=0, fwd_valid=0.
- in_valid=1, in_wr=1, in_src=MEM, in_mem=8'hA5, in_rd=2; read ra_addr=2 next cycle -> ra_data=A5 via bypass, fwd_rd=2; after second edge regfile[2]=A5, retired_cnt=1.
- Two consecutive writes to r1 (ALU 8'h11 then IMM 8'h22), rb_addr=1 -> 11 after first edge, 22 after second, 22 persistently thereafter.
- stall=1 for 3 cycles with entry LINK 8'h3C to r3 in stage -> no commit, fwd_data=3C held, in_ready=0, retired_cnt unchanged; release -> committed, count +1.
- flush=1 with in_valid=1 writing r1 -> s_valid=0, r1 unchanged, count unchanged; ZERO_R0=1 write 8'hFF to r0 -> fwd_valid=0, r0 reads 0, count +1.
- CNT_W=2, retire 5 instructions -> retired_cnt=3 (saturated); rst_n low mid-stream -> all outputs 0 immediately.
